exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_seq_pkg.sv | 30 +++
 rtl/exec_seq_decode.sv | 22 ++
 rtl/exec_sequencer.sv | 137 +++++++++++++
 tb/tb_exec_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// EXEC_SEQUENCER_SINGLE_STEP_EN adds the PAUSE state used for single stepping.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
`ifdef EXEC_SEQUENCER_SINGLE_STEP_EN
    S_HALT,
    S_PAUSE
`else
    S_HALT
`endif
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_SUB  = 4'h1;

  // Instruction word layout: opcode | rd | ra | rb, four bits each.
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;

endpackage

// File: rtl/exec_seq_decode.sv
// Combinational opcode classification for the sequencer.
module exec_seq_decode
  import exec_seq_pkg::*;
(
  input  logic [FIELD_W-1:0] opcode,
  output logic [2:0]         op_select,
  output logic               sub,
  output logic               is_alu,
  output logic               is_halt,
  output logic               is_illegal
);

  always_comb begin
    is_alu     = ~opcode[3];
    is_halt    = (opcode == OP_HALT);
    // Upper half minus NOP and HALT is unassigned.
    is_illegal = opcode[3] && (opcode != OP_NOP) && (opcode != OP_HALT);
    op_select  = is_alu ? opcode[2:0] : 3'd0;
    sub        = (opcode == OP_SUB);
  end

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving an external ALU and register file.
// Define EXEC_SEQUENCER_SINGLE_STEP_EN to add the step input and PAUSE state.
//
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | if_req high until if_ack, IR captured on ack
//   DECODE | classify IR; NOP/illegal retire here
//   EXEC   | ALU evaluates, flags captured at end of cycle
//   WB     | one-cycle wb_en, PC advances
//   HALT   | terminal until reset
//   PAUSE  | (single step only) wait for step after each retire
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
`ifdef EXEC_SEQUENCER_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              if_req,
  output logic [PC_W-1:0]   if_addr,
  input  logic              if_ack,
  input  logic [DATA_W-1:0] if_data,
  output logic [3:0]        address_a,
  output logic [3:0]        address_b,
  output logic [2:0]        op_select,
  output logic              sub,
  input  logic [3:0]        alu_flags,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              illegal
);

  state_t              state, state_next;
  logic [PC_W-1:0]     pc;
  logic [DATA_W-1:0]   ir;
  logic                is_alu, is_halt, is_illegal;
  logic                retire_nop;

  exec_seq_decode u_decode (
    .opcode     (ir[OPC_LSB +: FIELD_W]),
    .op_select  (op_select),
    .sub        (sub),
    .is_alu     (is_alu),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign address_a  = ir[RA_LSB +: FIELD_W];
  assign address_b  = ir[RB_LSB +: FIELD_W];
  assign wb_addr    = ir[RD_LSB +: FIELD_W];
  assign if_addr    = pc;
  assign retire_nop = (state == S_DECODE) && !is_alu && !is_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if_req     = 1'b0;
    wb_en      = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if_req = 1'b1;
        if (if_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu) begin
          state_next = S_EXEC;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else begin
`ifdef EXEC_SEQUENCER_SINGLE_STEP_EN
          state_next = S_PAUSE;
`else
          state_next = run ? S_FETCH : S_IDLE;
`endif
        end
      end
      S_EXEC: begin
        state_next = S_WB;
      end
      S_WB: begin
        wb_en = 1'b1;
`ifdef EXEC_SEQUENCER_SINGLE_STEP_EN
        state_next = S_PAUSE;
`else
        state_next = run ? S_FETCH : S_IDLE;
`endif
      end
      S_HALT: begin
        halted = 1'b1;
      end
`ifdef EXEC_SEQUENCER_SINGLE_STEP_EN
      S_PAUSE: begin
        if (!run) begin
          state_next = S_IDLE;
        end else if (step) begin
          state_next = S_FETCH;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else begin
      if (state == S_FETCH && if_ack) ir <= if_data;
      if (state == S_EXEC) flags <= alu_flags;
      // PC wraps naturally at 2^PC_W.
      if (retire_nop || state == S_WB) pc <= pc + PC_W'(1);
      if (state == S_DECODE && is_illegal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (default build).
module tb_exec_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        if_req;
  logic [3:0]  if_addr;
  logic        if_ack;
  logic [15:0] if_data;
  logic [3:0]  address_a, address_b;
  logic [2:0]  op_select;
  logic        sub;
  logic [3:0]  alu_flags;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [3:0]  flags;
  logic        halted;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  exec_sequencer #(.PC_W(4), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
`ifdef EXEC_SEQUENCER_SINGLE_STEP_EN
    .step      (1'b1),
`endif
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_data   (if_data),
    .address_a (address_a),
    .address_b (address_b),
    .op_select (op_select),
    .sub       (sub),
    .alu_flags (alu_flags),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .flags     (flags),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    run    = 1'b0;
    if_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; if_ack = 1'b1; if_data = 16'hF0F0; alu_flags = 4'hF;
    #1;
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL reset_if_req got=%b want=0", if_req); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%b want=0", wb_en); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h want=0", flags); end
    total++; if (if_addr !== 4'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", if_addr); end
    total++; if ({address_a, address_b, wb_addr} !== 12'h000) begin bad++; $display("FAIL reset_ir_fields got=%h want=000", {address_a, address_b, wb_addr}); end
    tick();
    tick();
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL reset_held_if_req got=%b want=0", if_req); end
  endtask

  task automatic test_alu_basic();
    do_reset();
    run = 1'b1; if_ack = 1'b1; if_data = 16'h0123; alu_flags = 4'hA;
    tick();  // FETCH, cycle 1
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL alu_fetch_req got=%b want=1", if_req); end
    total++; if (if_addr !== 4'h0) begin bad++; $display("FAIL alu_fetch_addr got=%h want=0", if_addr); end
    tick();  // DECODE, cycle 2
    if_ack = 1'b0;
    total++; if (address_a !== 4'h2) begin bad++; $display("FAIL alu_addr_a got=%h want=2", address_a); end
    total++; if (address_b !== 4'h3) begin bad++; $display("FAIL alu_addr_b got=%h want=3", address_b); end
    total++; if (op_select !== 3'd0) begin bad++; $display("FAIL alu_op_select got=%0d want=0", op_select); end
    total++; if (wb_addr !== 4'h1) begin bad++; $display("FAIL alu_wb_addr got=%h want=1", wb_addr); end
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL alu_decode_req got=%b want=0", if_req); end
    tick();  // EXEC, cycle 3
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL alu_exec_wb_en got=%b want=0", wb_en); end
    tick();  // WB, cycle 4
    alu_flags = 4'h5;
    total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL alu_wb_pulse got=%b want=1", wb_en); end
    total++; if (flags !== 4'hA) begin bad++; $display("FAIL alu_flags got=%h want=a", flags); end
    tick();  // back to FETCH
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL alu_wb_one_cycle got=%b want=0", wb_en); end
    total++; if (if_addr !== 4'h1) begin bad++; $display("FAIL alu_pc_inc got=%h want=1", if_addr); end
    total++; if (if_req !== 1'b1) begin bad++; $display("FAIL alu_refetch got=%b want=1", if_req); end
    total++; if (flags !== 4'hA) begin bad++; $display("FAIL alu_flags_hold got=%h want=a", flags); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL async_reset_flags got=%h want=0", flags); end
    total++; if (if_addr !== 4'h0) begin bad++; $display("FAIL async_reset_pc got=%h want=0", if_addr); end
    total++; if (if_req !== 1'b0) begin bad++; $display("FAIL async_reset_if_req got=%b want=0", if_req); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_ack_delay();
    int cyc;
    do_reset();
    run = 1'b1; if_ack = 1'b0; if_data = 16'h0123; alu_flags = 4'h0;
    tick();  // FETCH cycle 1
    for (int i = 0; i < 3; i++) begin
      total++; if (if_req !== 1'b1) begin bad++; $display("FAIL delay_req_held i=%0d got=%b want=1", i, if_req); end
      total++; if (address_a !== 4'h0) begin bad++; $display("FAIL delay_ir_held i=%0d got=%h want=0", i, address_a); end
      tick();
    end
    if_ack = 1'b1;  // acked in FETCH cycle 4
    tick();
    if_ack = 1'b0;
    cyc = 5;
    total++; if (address_a !== 4'h2) begin bad++; $display("FAIL delay_ir_load got=%h want=2", address_a); end
    while (wb_en !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    total++; if (cyc !== 7) begin bad++; $display("FAIL delay_wb_cycle got=%0d want=7", cyc); end
  endtask

  task automatic test_nop_wrap();
    int exp_pc;
    int fetches;
    int wb_seen;
    do_reset();
    run = 1'b1; if_ack = 1'b1; if_data = 16'h8000;
    exp_pc = 0; fetches = 0; wb_seen = 0;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (wb_en) wb_seen++;
      if (if_req) begin
        total++; if (if_addr !== exp_pc[3:0]) begin bad++; $display("FAIL nop_addr fetch=%0d got=%h want=%h", fetches, if_addr, exp_pc[3:0]); end
        exp_pc = (exp_pc + 1) % 16;
        fetches++;
      end
    end
    total++; if (fetches !== 17) begin bad++; $display("FAIL nop_fetch_count got=%0d want=17", fetches); end
    total++; if (wb_seen !== 0) begin bad++; $display("FAIL nop_wb_en got=%0d want=0", wb_seen); end
  endtask

  task automatic test_decode_table();
    logic [3:0] opc;
    logic       exp_alu, exp_halt, exp_ill;
    for (int op = 0; op < 16; op++) begin
      opc      = op[3:0];
      exp_alu  = (op < 8);
      exp_halt = (op == 15);
      exp_ill  = (op >= 9) && (op <= 14);
      do_reset();
      run = 1'b1; if_ack = 1'b1; if_data = {opc, 12'h321};
      tick();
      tick();  // DECODE
      if_ack = 1'b0;
      if (exp_alu) begin
        total++; if (op_select !== opc[2:0]) begin bad++; $display("FAIL dec_op_select op=%0d got=%0d want=%0d", op, op_select, opc[2:0]); end
      end
      total++; if (sub !== (op == 1)) begin bad++; $display("FAIL dec_sub op=%0d got=%b want=%b", op, sub, (op == 1)); end
      total++; if ({wb_addr, address_a, address_b} !== 12'h321) begin bad++; $display("FAIL dec_fields op=%0d got=%h want=321", op, {wb_addr, address_a, address_b}); end
      tick();
      total++; if (halted !== exp_halt) begin bad++; $display("FAIL dec_halted op=%0d got=%b want=%b", op, halted, exp_halt); end
      total++; if (illegal !== exp_ill) begin bad++; $display("FAIL dec_illegal op=%0d got=%b want=%b", op, illegal, exp_ill); end
      total++; if (if_req !== (!exp_alu && !exp_halt)) begin bad++; $display("FAIL dec_next_fetch op=%0d got=%b want=%b", op, if_req, (!exp_alu && !exp_halt)); end
    end
  endtask

  task automatic test_illegal_sticky();
    do_reset();
    run = 1'b1; if_ack = 1'b1; if_data = 16'hA000;
    tick();
    tick();  // DECODE of illegal word
    if_data = 16'h0123;
    tick();  // FETCH at PC=1
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_set got=%b want=1", illegal); end
    total++; if (if_addr !== 4'h1) begin bad++; $display("FAIL ill_pc got=%h want=1", if_addr); end
    tick();
    if_ack = 1'b0;
    tick();
    tick();  // WB of valid instruction
    total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL ill_valid_wb got=%b want=1", wb_en); end
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b want=1", illegal); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_cleared got=%b want=0", illegal); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; if_ack = 1'b1; if_data = 16'h8000;
    tick();
    tick();  // DECODE NOP
    if_data = 16'hF000;
    tick();  // FETCH PC=1
    tick();  // DECODE HALT
    tick();  // HALT
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_entered got=%b want=1", halted); end
    for (int i = 0; i < 4; i++) begin
      total++; if ({if_req, wb_en, halted} !== 3'b001) begin bad++; $display("FAIL halt_stuck i=%0d got=%b want=001", i, {if_req, wb_en, halted}); end
      tick();
    end
    total++; if (if_addr !== 4'h1) begin bad++; $display("FAIL halt_pc got=%h want=1", if_addr); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b want=0", halted); end
    total++; if (if_addr !== 4'h0) begin bad++; $display("FAIL halt_reset_pc got=%h want=0", if_addr); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_run_drop();
    int reqs;
    do_reset();
    run = 1'b1; if_ack = 1'b1; if_data = 16'h1456; alu_flags = 4'h6;
    tick();
    tick();  // DECODE
    total++; if (sub !== 1'b1) begin bad++; $display("FAIL drop_sub got=%b want=1", sub); end
    total++; if (op_select !== 3'd1) begin bad++; $display("FAIL drop_op_select got=%0d want=1", op_select); end
    total++; if (wb_addr !== 4'h4) begin bad++; $display("FAIL drop_wb_addr got=%h want=4", wb_addr); end
    tick();  // EXEC
    run = 1'b0;
    tick();  // WB
    total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL drop_wb got=%b want=1", wb_en); end
    tick();  // IDLE
    total++; if (flags !== 4'h6) begin bad++; $display("FAIL drop_flags got=%h want=6", flags); end
    total++; if (if_addr !== 4'h1) begin bad++; $display("FAIL drop_pc got=%h want=1", if_addr); end
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_req || wb_en) reqs++;
      tick();
    end
    total++; if (reqs !== 0) begin bad++; $display("FAIL drop_idle_activity got=%0d want=0", reqs); end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; if_ack = 1'b0; if_data = 16'h0; alu_flags = 4'h0;
    test_reset();
    test_alu_basic();
    test_ack_delay();
    test_nop_wrap();
    test_decode_table();
    test_illegal_sticky();
    test_halt();
    test_run_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
